// File: rtl/core_seq.sv
// -----------------------------------------------------------------------------
// core_seq -- command-driven sequencer for the 8-entry matrix-row MAC core.
//
// Accepts LOAD (write rows) and RUN (stream a vector, collect the dot product)
// commands. It drives the core strobes/addresses/data with the pipeline
// alignment the core expects, then returns the core accumulator on a
// valid/ready result port.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_op     command handshake; op 0 = LOAD, 1 = RUN
//   cmd_len[2:0]                    entry count minus one
//   din_valid/din_ready, din[31:0]  operand stream (rows for LOAD, vector for RUN)
//   init, write, exec               core strobes (registered)
//   wa, ra [2:0], wd, d [31:0]      core addresses and data (registered)
//   acc[31:0]                       core accumulator
//   res_valid/res_ready, res[31:0]  result handshake
//
// Optional build macro CORE_SEQ_PERF_EN adds perf_busy / perf_stall counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module core_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [2:0]  cmd_len,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [31:0] din,
  output logic        init,
  output logic        write,
  output logic        exec,
  output logic [2:0]  wa,
  output logic [2:0]  ra,
  output logic [31:0] wd,
  output logic [31:0] d,
  input  logic [31:0] acc,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [31:0] perf_busy,
  output logic [31:0] perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [2:0]  r_len;
  logic [1:0]  r_drain;
  logic [31:0] r_d1;     // first stage of the din -> d alignment pipe

  // Handshake flags decode state directly so they react in the same cycle.
  assign cmd_ready = (r_state == S_IDLE);
  assign din_ready = (r_state == S_LOAD) || (r_state == S_RUN);
  assign res_valid = (r_state == S_RESP);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_drain <= '0;
      r_d1    <= '0;
      init    <= 1'b0;
      write   <= 1'b0;
      exec    <= 1'b0;
      wa      <= '0;
      ra      <= '0;
      wd      <= '0;
      d       <= '0;
      res     <= '0;
    end else begin
      // NOTE: strobes default low every cycle, so each one is a single-cycle
      // pulse unless the state below re-asserts it.
      init  <= 1'b0;
      write <= 1'b0;
      exec  <= 1'b0;

      // Second stage of the data pipe: d advances only behind a real exec, so
      // it lands in the cycle the core multiplies and holds across bubbles.
      // This keeps running through DRAIN for the final word.
      if (exec) d <= r_d1;

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_len <= cmd_len;
            r_idx <= '0;
            if (cmd_op) begin
              r_state <= S_CLEAR;
              init    <= 1'b1;   // high during the single CLEAR cycle
            end else begin
              r_state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (din_valid) begin
            write <= 1'b1;
            wa    <= r_idx;
            wd    <= din;
            r_idx <= r_idx + 3'd1;
            if (r_idx == r_len) r_state <= S_IDLE;
          end
        end

        S_CLEAR: r_state <= S_RUN;

        S_RUN: begin
          if (din_valid) begin
            exec  <= 1'b1;
            ra    <= r_idx;
            r_d1  <= din;
            r_idx <= r_idx + 3'd1;
            if (r_idx == r_len) begin
              r_state <= S_DRAIN;
              r_drain <= '0;
            end
          end
        end

        // Four cycles cover the core's read, multiply and accumulate stages;
        // acc is final in the last DRAIN cycle.
        S_DRAIN: begin
          r_drain <= r_drain + 2'd1;
          if (r_drain == 2'd3) begin
            res     <= acc;
            r_state <= S_RESP;
          end
        end

        S_RESP: if (res_ready) r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef CORE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (r_state != S_IDLE) perf_busy <= perf_busy + 32'd1;
      if (((r_state == S_RUN)  && !din_valid) ||
          ((r_state == S_RESP) && !res_ready))
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_seq.sv
// -----------------------------------------------------------------------------
// tb_core_seq -- directed bench for core_seq, with a behavioural model of the
// MAC core (row memory, read -> multiply -> accumulate pipeline) attached.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_core_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_op;
  logic [2:0]  cmd_len;
  logic        cmd_ready;
  logic        din_valid;
  logic [31:0] din;
  logic        din_ready;
  logic        init, write, exec;
  logic [2:0]  wa, ra;
  logic [31:0] wd, d, acc, res;
  logic        res_valid, res_ready;
`ifdef CORE_SEQ_PERF_EN
  logic [31:0] perf_busy, perf_stall;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int n_overlap = 0;
  logic [31:0] vec [0:7];

  always #5 clk = ~clk;

  core_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .init      (init),
    .write     (write),
    .exec      (exec),
    .wa        (wa),
    .ra        (ra),
    .wd        (wd),
    .d         (d),
    .acc       (acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res)
`ifdef CORE_SEQ_PERF_EN
    ,
    .perf_busy (perf_busy),
    .perf_stall(perf_stall)
`endif
  );

  // ---------------- MAC core model ----------------
  // exec/ra at t -> row read at t+1 (with d) -> product at t+2 -> acc at t+3.
  // Row storage is not cleared by reset.
  logic [31:0] rows [0:7];
  logic        e1, e2;
  logic [31:0] rv, prod, acc_q;
  assign acc = acc_q;

  initial for (int i = 0; i < 8; i++) rows[i] = '0;

  always @(posedge clk) if (write) rows[wa] <= wd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1 <= 1'b0; e2 <= 1'b0; rv <= '0; prod <= '0; acc_q <= '0;
    end else begin
      e1   <= exec;
      rv   <= rows[ra];
      e2   <= e1;
      prod <= rv * d;
      if (init)    acc_q <= '0;
      else if (e2) acc_q <= acc_q + prod;
    end
  end

  // Strobe exclusivity monitor.
  always @(negedge clk)
    if (rst_n && exec && (write || init)) n_overlap++;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // LOAD n rows from vec[0..n-1].
  task automatic do_load(input int n);
    check("load_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_len = 3'(n - 1);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1; din = vec[i];
      step();
      check("load_write", write, 1'b1);
      check("load_wa", wa, 32'(i));
      check("load_wd", wd, vec[i]);
    end
    din_valid = 1'b0;
    check("load_back_idle", cmd_ready, 1'b1);
  endtask

  // Hold the result for `hold` cycles (with a stray command), then accept it.
  task automatic do_resp(input int hold);
    logic [31:0] held;
    held = res;
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_len = 3'd0;
    for (int i = 0; i < hold; i++) begin
      step();
      check("resp_hold_valid", res_valid, 1'b1);
      check("resp_hold_res", res, held);
      check("resp_cmd_ignored", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("resp_done_valid", res_valid, 1'b0);
    check("resp_done_idle", cmd_ready, 1'b1);
    step();
    check("resp_no_stray_load", din_ready, 1'b0);
  endtask

  // RUN with n words from vec[], `gap` bubbles between words.
  task automatic do_run(input int n, input int gap, input logic [31:0] exp, input int hold);
    int lat;
    check("run_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 3'(n - 1);
    step();
    cmd_valid = 1'b0;
    check("run_init_a1", init, 1'b1);
    check("run_din_ready_a1", din_ready, 1'b0);
    step();
    check("run_init_a2", init, 1'b0);
    check("run_din_ready_a2", din_ready, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          din_valid = 1'b0;
          step();
          check("bubble_exec", exec, 1'b0);
        end
      end
      din_valid = 1'b1; din = vec[i];
      step();
      check("run_exec", exec, 1'b1);
      check("run_ra", ra, 32'(i));
    end
    din_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 20) begin
      step();
      lat++;
      if (lat == 2) check("run_d_last", d, vec[n-1]);
    end
    check("run_latency", 32'(lat), 32'd5);
    check("run_res", res, exp);
    do_resp(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] stall0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = '0;
    din_valid = 1'b0; din = '0; res_ready = 1'b0;
    stall0 = '0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state.
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_din_ready", din_ready, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_strobes", {29'd0, init, write, exec}, 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_d", d, 32'd0);
`ifdef CORE_SEQ_PERF_EN
    check("rst_perf_busy", perf_busy, 32'd0);
`endif

    // Rows 1..4, vector 5..8 -> 5+12+21+32 = 70.
    for (int i = 0; i < 4; i++) vec[i] = 32'(i + 1);
    do_load(4);
    for (int i = 0; i < 4; i++) vec[i] = 32'(i + 5);
    do_run(4, 0, 32'd70, 0);

    // Same RUN with 2 bubbles between words, 3 RESP wait cycles.
`ifdef CORE_SEQ_PERF_EN
    stall0 = perf_stall;
`endif
    do_run(4, 2, 32'd70, 3);
`ifdef CORE_SEQ_PERF_EN
    check("perf_stall_delta", perf_stall - stall0, 32'd9);
`endif

    // Wrapping product: 0x10000 * 0x10000 mod 2^32 = 0.
    vec[0] = 32'h0001_0000;
    do_load(1);
    do_run(1, 0, 32'd0, 0);
    // init clears the previous accumulation: 3 * 2 = 6; long RESP hold.
    vec[0] = 32'd3;
    do_load(1);
    vec[0] = 32'd2;
    do_run(1, 0, 32'd6, 10);

    // Reset in the middle of an 8-word RUN.
    for (int i = 0; i < 8; i++) vec[i] = 32'(i + 1);
    do_load(8);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 3'd7;
    step();
    cmd_valid = 1'b0;
    step();
    din_valid = 1'b1; din = 32'd11;
    step();
    din = 32'd12;
    step();
    #2 rst_n = 1'b0;
    #1;
    din_valid = 1'b0;
    check("midrst_exec", exec, 1'b0);
    check("midrst_init_write", {30'd0, init, write}, 32'd0);
    check("midrst_ra", ra, 32'd0);
    check("midrst_wa", wa, 32'd0);
    check("midrst_wd", wd, 32'd0);
    check("midrst_d", d, 32'd0);
    check("midrst_res", res, 32'd0);
    check("midrst_res_valid", res_valid, 1'b0);
    check("midrst_din_ready", din_ready, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    step(); step();
    rst_n = 1'b1;
    step();
    // Rows 1..8 survive; vector 1..8 -> sum of squares = 204.
    do_run(8, 0, 32'd204, 0);

    check("strobe_overlap", 32'(n_overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
